// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor run/step controller.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    HALT  = 2'b11
  } ctrl_state_e;

  localparam int STEP_CNT_W   = 14;
  localparam int STEP_CNT_MAX = 9999;

  // Decimal-range increment: the counter feeds a 4-digit display, so it wraps 9999 -> 0.
  function automatic logic [STEP_CNT_W-1:0] step_cnt_inc(input logic [STEP_CNT_W-1:0] v);
    if (v == STEP_CNT_W'(STEP_CNT_MAX)) begin
      return '0;
    end
    return v + STEP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider used in RUN: counts 0..DIV-1 while enabled and is held
// at 0 otherwise, so every entry into RUN starts a full period.
module tick_prescaler #(
  parameter int DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick is combinational so the controller can register proc_en in the same cycle.
  assign tick = en && (cnt_q == LAST);

  // Next count: wrap at DIV-1, clear whenever disabled.
  always_comb begin
    cnt_d = '0;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/proc_step_ctrl.sv
// Run/step sequencer: produces the processor clock enable (periodic in RUN,
// one per step request in PAUSE, none in HALT) and a 0..9999 step counter
// for the FND display. Optional build macro PROC_CTRL_STEP_LIMIT_EN enables
// auto-halt when the step counter reaches STEP_LIMIT.
module proc_step_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int DIV        = 10_000_000,
  parameter int STEP_LIMIT = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_btn,
  input  logic                  step_btn,
  input  logic                  clr_btn,
  input  logic                  halt_req,
  output logic                  proc_en,
  output logic [1:0]            state,
  output logic [STEP_CNT_W-1:0] step_cnt
);

`ifdef PROC_CTRL_STEP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [STEP_CNT_W-1:0] LIMIT = STEP_CNT_W'(STEP_LIMIT);

  ctrl_state_e           state_q, state_d;
  logic                  proc_en_q, proc_en_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  tick;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == RUN),
    .tick (tick)
  );

  // Next state, next enable and counter update; halt_req outranks every button.
  always_comb begin
    state_d   = state_q;
    proc_en_d = 1'b0;
    cnt_d     = cnt_q;

    // Count lags the enable by one cycle.
    if (proc_en_q) begin
      cnt_d = step_cnt_inc(cnt_q);
    end

    case (state_q)
      PAUSE: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (run_btn) begin
          state_d = RUN;
        end else if (step_btn) begin
          state_d = STEP;
        end else if (clr_btn) begin
          cnt_d = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (run_btn) begin
          state_d = PAUSE;           // a tick coinciding with the pause press is dropped
        end else if (tick) begin
          proc_en_d = 1'b1;
        end
      end
      STEP: begin
        if (halt_req) begin
          state_d = HALT;
        end else begin
          state_d   = PAUSE;
          proc_en_d = 1'b1;
        end
      end
      HALT: begin
        if (clr_btn && !halt_req) begin
          state_d = PAUSE;
          cnt_d   = '0;
        end
      end
      default: state_d = PAUSE;
    endcase

    // Auto-halt on the edge where the count reaches the limit.
    if (LIMIT_EN && proc_en_q && (cnt_d == LIMIT)) begin
      state_d = HALT;
    end
  end

  // State, enable and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PAUSE;
      proc_en_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      proc_en_q <= proc_en_d;
      cnt_q     <= cnt_d;
    end
  end

  assign proc_en  = proc_en_q;
  assign state    = state_q;
  assign step_cnt = cnt_q;

endmodule
